// File: rtl/pipeline_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl_pkg
// Shared definitions for the RV32 pipeline stall/flush sequencer:
//   - state_e        : sequencer state encoding (RUN / MEM_WAIT / FAULT)
//   - ZERO_VECTOR_5  : register index x0, which never carries a hazard
// ---------------------------------------------------------------------------
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  localparam logic [4:0] ZERO_VECTOR_5 = 5'd0;

endpackage

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detector. Flags when the instruction in EX
// is a load whose destination is read by the instruction currently in ID.
// Ports:
//   i_id_rs1, i_id_rs2 : source registers of the ID instruction
//   i_id_uses_rs2      : ID instruction actually reads rs2
//   i_ex_memread       : EX instruction is a load
//   i_ex_rd            : destination register of the EX instruction
//   o_lu               : hazard present, ID must wait one cycle
// ---------------------------------------------------------------------------
module load_use_detect
  import pipeline_stall_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_uses_rs2,
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rd,
  output logic       o_lu
);

  logic w_rd_live;
  logic w_hit_rs1;
  logic w_hit_rs2;

  // x0 is hard-wired zero, so a load targeting it never produces a value.
  assign w_rd_live = (i_ex_rd != ZERO_VECTOR_5);
  assign w_hit_rs1 = (i_ex_rd == i_id_rs1);
  // rs2 field holds immediate bits on I/U/J types; only compare when used.
  assign w_hit_rs2 = i_id_uses_rs2 & (i_ex_rd == i_id_rs2);

  assign o_lu = i_ex_memread & w_rd_live & (w_hit_rs1 | w_hit_rs2);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
// Central stall/flush sequencer for the 5-stage RV32 pipeline. Sits beside
// EX/MEM and drives the load enables and bubble-flushes of the PC and the
// four pipeline registers. Handles load-use stalls, taken-branch squash and
// variable-latency data-memory waits, with a sticky wait timeout and a
// saturating stall-cycle counter.
// Parameters:
//   TIMEOUT_CYCLES : MEM_WAIT cycles tolerated without dmem_ready (>=1)
//   CNT_W          : width of the stall_cycles counter
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   ID_rs1, ID_rs2, ID_uses_rs2: operands of the instruction in ID
//   EX_MemRead, EX_rd          : load / destination of the instruction in EX
//   EX_branch_taken            : branch/jump in EX resolved taken
//   MEM_MemRead, MEM_MemWrite  : load / store in MEM
//   dmem_ready                 : data memory completes this cycle
//   dmem_req                   : data memory request
//   PC_en .. MEM_WB_en         : pipeline register load enables
//   IF_ID_flush, ID_EX_flush,
//   MEM_WB_flush               : load a bubble when enabled
//   mem_timeout                : sticky wait-timeout fault
//   stall_cycles               : saturating count of cycles with PC_en==0
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_uses_rs2,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_rd,
  input  logic             EX_branch_taken,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             PC_en,
  output logic             IF_ID_en,
  output logic             ID_EX_en,
  output logic             EX_MEM_en,
  output logic             MEM_WB_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             MEM_WB_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(TIMEOUT_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WC_W-1:0]   r_wait_cnt;
  logic [WC_W-1:0]   w_wait_cnt_nxt;
  logic              r_mem_timeout;
  logic              w_mem_timeout_nxt;
  logic [CNT_W-1:0]  r_stall_cycles;

  logic              w_mem_acc;
  logic              w_freeze;
  logic              w_lu;

  load_use_detect u_lu (
    .i_id_rs1      (ID_rs1),
    .i_id_rs2      (ID_rs2),
    .i_id_uses_rs2 (ID_uses_rs2),
    .i_ex_memread  (EX_MemRead),
    .i_ex_rd       (EX_rd),
    .o_lu          (w_lu)
  );

  assign w_mem_acc = MEM_MemRead | MEM_MemWrite;
  assign w_freeze  = w_mem_acc & ~dmem_ready;

  // Next state and outputs. Everything is forced low while reset is held.
  always_comb begin
    w_state_nxt       = r_state;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_mem_timeout_nxt = r_mem_timeout;
    dmem_req          = 1'b0;
    PC_en             = 1'b0;
    IF_ID_en          = 1'b0;
    ID_EX_en          = 1'b0;
    EX_MEM_en         = 1'b0;
    MEM_WB_en         = 1'b0;
    IF_ID_flush       = 1'b0;
    ID_EX_flush       = 1'b0;
    MEM_WB_flush      = 1'b0;
    mem_timeout       = 1'b0;

    if (reset) begin
      mem_timeout = r_mem_timeout;
      unique case (r_state)
        ST_RUN, ST_MEM_WAIT: begin
          dmem_req = w_mem_acc;
          if (w_freeze) begin
            // Hold the whole pipe; WB takes a bubble so the instruction
            // already written back is not committed a second time.
            MEM_WB_en    = 1'b1;
            MEM_WB_flush = 1'b1;
            if (r_state == ST_RUN) begin
              w_state_nxt    = ST_MEM_WAIT;
              w_wait_cnt_nxt = WC_W'(1);
            end else if (r_wait_cnt == WC_LIMIT) begin
              w_state_nxt       = ST_FAULT;
              w_mem_timeout_nxt = 1'b1;
            end else begin
              w_wait_cnt_nxt = r_wait_cnt + WC_W'(1);
            end
          end else begin
            w_state_nxt    = ST_RUN;
            w_wait_cnt_nxt = '0;
            PC_en          = 1'b1;
            IF_ID_en       = 1'b1;
            ID_EX_en       = 1'b1;
            EX_MEM_en      = 1'b1;
            MEM_WB_en      = 1'b1;
            if (EX_branch_taken) begin
              // Squash the wrong-path instructions; any load-use consumer
              // is among them, so no stall is needed.
              IF_ID_flush = 1'b1;
              ID_EX_flush = 1'b1;
            end else if (w_lu) begin
              PC_en       = 1'b0;
              IF_ID_en    = 1'b0;
              ID_EX_flush = 1'b1;
            end
          end
        end
        ST_FAULT: begin
          w_mem_timeout_nxt = 1'b1;
        end
        default: begin
          w_state_nxt       = ST_FAULT;
          w_mem_timeout_nxt = 1'b1;
        end
      endcase
    end
  end

  // State, wait counter, fault flag and stall counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= ST_RUN;
      r_wait_cnt     <= '0;
      r_mem_timeout  <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_mem_timeout <= w_mem_timeout_nxt;
      if (!PC_en) begin
        r_stall_cycles <= sat_inc(r_stall_cycles);
      end
    end
  end

  assign stall_cycles = reset ? r_stall_cycles : '0;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
// Directed bench for pipeline_stall_ctrl with TIMEOUT_CYCLES=4, CNT_W=4.
// Outputs are packed as
//   {dmem_req, PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
//    IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_timeout}
// Inputs change 1 time unit after posedge; outputs are checked at negedge.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

  localparam int CNT_W = 4;

  // Hand-derived output patterns
  localparam logic [9:0] P_RST    = 10'b0_00000_000_0;
  localparam logic [9:0] P_NORM   = 10'b0_11111_000_0;
  localparam logic [9:0] P_LU     = 10'b0_00111_010_0;
  localparam logic [9:0] P_BR     = 10'b0_11111_110_0;
  localparam logic [9:0] P_FRZ    = 10'b1_00001_001_0;
  localparam logic [9:0] P_MEM_BR = 10'b1_11111_110_0;
  localparam logic [9:0] P_MEM_OK = 10'b1_11111_000_0;
  localparam logic [9:0] P_FAULT  = 10'b0_00000_000_1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       ID_rs1, ID_rs2, EX_rd;
  logic             ID_uses_rs2, EX_MemRead, EX_branch_taken;
  logic             MEM_MemRead, MEM_MemWrite, dmem_ready;
  logic             dmem_req, PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en;
  logic             IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [9:0]       ctrl;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .ID_rs1          (ID_rs1),
    .ID_rs2          (ID_rs2),
    .ID_uses_rs2     (ID_uses_rs2),
    .EX_MemRead      (EX_MemRead),
    .EX_rd           (EX_rd),
    .EX_branch_taken (EX_branch_taken),
    .MEM_MemRead     (MEM_MemRead),
    .MEM_MemWrite    (MEM_MemWrite),
    .dmem_ready      (dmem_ready),
    .dmem_req        (dmem_req),
    .PC_en           (PC_en),
    .IF_ID_en        (IF_ID_en),
    .ID_EX_en        (ID_EX_en),
    .EX_MEM_en       (EX_MEM_en),
    .MEM_WB_en       (MEM_WB_en),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EX_flush     (ID_EX_flush),
    .MEM_WB_flush    (MEM_WB_flush),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles)
  );

  assign ctrl = {dmem_req, PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
                 IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_timeout};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rst_n,
                        input logic ex_mr, input logic [4:0] ex_rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic uses2, input logic br,
                        input logic mr, input logic mw, input logic rdy);
    reset           = rst_n;
    EX_MemRead      = ex_mr;
    EX_rd           = ex_rd;
    ID_rs1          = rs1;
    ID_rs2          = rs2;
    ID_uses_rs2     = uses2;
    EX_branch_taken = br;
    MEM_MemRead     = mr;
    MEM_MemWrite    = mw;
    dmem_ready      = rdy;
  endtask

  task automatic chk_cyc(input string tag, input logic [9:0] e_ctrl, input int e_stall);
    @(negedge clk);
    chk({tag, "/ctrl"}, 32'(ctrl), 32'(e_ctrl));
    chk({tag, "/stall"}, 32'(stall_cycles), e_stall);
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cyc();
    next_cyc();
    chk_cyc("reset_hold", P_RST, 0);

    // Normal running
    next_cyc(); set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_cyc("run_idle", P_NORM, 0);

    // Load-use on rs1: one bubble, then hazard gone
    next_cyc(); set_in(1, 1, 5, 5, 0, 0, 0, 0, 0, 0);
    chk_cyc("lu_rs1", P_LU, 0);
    next_cyc(); set_in(1, 0, 5, 5, 0, 0, 0, 0, 0, 0);
    chk_cyc("lu_clear", P_NORM, 1);

    // Load into x0 never stalls
    next_cyc(); set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_cyc("lu_x0", P_NORM, 1);

    // rs2 match only counts when rs2 is used
    next_cyc(); set_in(1, 1, 7, 3, 7, 0, 0, 0, 0, 0);
    chk_cyc("lu_rs2_unused", P_NORM, 1);
    next_cyc(); set_in(1, 1, 7, 3, 7, 1, 0, 0, 0, 0);
    chk_cyc("lu_rs2_used", P_LU, 1);

    // Taken branch overrides load-use
    next_cyc(); set_in(1, 1, 7, 3, 7, 1, 1, 0, 0, 0);
    chk_cyc("br_over_lu", P_BR, 2);
    next_cyc(); set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_cyc("br_done", P_NORM, 2);

    // Memory wait: 3 frozen cycles (freeze beats branch), then release
    next_cyc(); set_in(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    chk_cyc("wait_1", P_FRZ, 2);
    next_cyc();
    chk_cyc("wait_2", P_FRZ, 3);
    next_cyc();
    chk_cyc("wait_3", P_FRZ, 4);
    next_cyc(); dmem_ready = 1'b1;
    chk_cyc("wait_ready", P_MEM_BR, 5);
    next_cyc(); set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_cyc("wait_after", P_NORM, 5);

    // Reset clears the counter
    next_cyc(); reset = 1'b0;
    chk_cyc("reset_pulse", P_RST, 0);
    next_cyc(); reset = 1'b1;
    chk_cyc("reset_cleared", P_NORM, 0);

    // Timeout: store never completes
    next_cyc(); set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk_cyc("to_run", P_FRZ, 0);
    for (int i = 1; i <= 4; i++) begin
      next_cyc();
      chk_cyc($sformatf("to_wait%0d", i), P_FRZ, i);
    end
    next_cyc();
    chk_cyc("to_fault", P_FAULT, 5);
    next_cyc(); dmem_ready = 1'b1;
    chk_cyc("to_sticky_rdy", P_FAULT, 6);
    next_cyc(); set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_cyc("to_sticky_idle", P_FAULT, 7);

    // Keep stalling in FAULT until the counter must saturate
    for (int i = 0; i < 20; i++) next_cyc();
    chk_cyc("sat", P_FAULT, 15);

    // Reset while waiting on memory
    next_cyc(); reset = 1'b0;
    chk_cyc("fault_reset", P_RST, 0);
    next_cyc(); set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk_cyc("mw_enter", P_FRZ, 0);
    next_cyc();
    chk_cyc("mw_hold", P_FRZ, 1);
    next_cyc(); reset = 1'b0;
    chk_cyc("mw_reset", P_RST, 0);
    next_cyc(); set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk_cyc("mw_after_reset", P_MEM_OK, 0);

    // Wait counter must have restarted: full 4-cycle budget again
    next_cyc(); dmem_ready = 1'b0;
    chk_cyc("mw2_run", P_FRZ, 0);
    for (int i = 1; i <= 4; i++) begin
      next_cyc();
      chk_cyc($sformatf("mw2_wait%0d", i), P_FRZ, i);
    end
    next_cyc();
    chk_cyc("mw2_fault", P_FAULT, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
